// File: rtl/lsu_mem_sequencer_pkg.sv
// Shared types for the LSU memory sequencer: operator codes, FSM states and the word byte-enable.
package lsu_mem_sequencer_pkg;

  typedef enum logic [1:0] {
    LSU_NONE = 2'b00,
    LSU_LW   = 2'b01,
    LSU_SW   = 2'b10
  } load_store_func_code;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } lsu_seq_state_e;

  localparam logic [3:0] LSU_BE_WORD = 4'hF;

  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/lsu_mem_sequencer.sv
// Sequences one LW/SW at a time onto the req/gnt/rvalid data bus; load result 1 cycle after rvalid.
// Holds upstream via lsu_busy_op while REQ/WAIT; optional abort timer under LSU_TIMEOUT_EN.
// Latency: accept c0, req c1, rvalid >= c2, load_valid_op >= c3. Upstream inputs ignored while busy.
module lsu_mem_sequencer
  import lsu_mem_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  lsu_en_ip,
  input  logic [1:0]            lsu_operator_ip,
  input  logic                  alu_valid_ip,
  input  logic [ADDR_WIDTH-1:0] mem_addr_ip,
  input  logic [31:0]           mem_wdata_ip,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  input  logic [31:0]           data_rdata_i,
  output logic                  data_req_op,
  output logic                  data_we_op,
  output logic [3:0]            data_be_op,
  output logic [ADDR_WIDTH-1:0] data_addr_op,
  output logic [31:0]           data_wdata_op,
  output logic                  lsu_busy_op,
  output logic [31:0]           load_mem_data_op,
  output logic                  load_valid_op,
  output logic                  misaligned_err_op,
  output logic                  timeout_err_op
);

  if (TIMEOUT_CYCLES < 2 || ADDR_WIDTH < 2) begin : g_param_check
    $error("lsu_mem_sequencer: TIMEOUT_CYCLES and ADDR_WIDTH must both be >= 2");
  end

  lsu_seq_state_e r_state;
  lsu_seq_state_e w_state_nxt;

  logic                  r_we;
  logic [3:0]            r_be;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_ldata;
  logic                  r_load_vld;
  logic                  r_misaligned;
  logic                  r_timeout;

  logic w_is_mem_op;
  logic w_accept;
  logic w_start;
  logic w_misalign;
  logic w_done;
  logic w_timeout;

  // Unknown operator codes are silently dropped, so they never raise a misalignment error.
  assign w_is_mem_op = (lsu_operator_ip == LSU_LW) || (lsu_operator_ip == LSU_SW);
  assign w_accept    = (r_state == ST_IDLE) && lsu_en_ip && alu_valid_ip && w_is_mem_op;
  assign w_start     = w_accept && is_word_aligned(mem_addr_ip[1:0]);
  assign w_misalign  = w_accept && !is_word_aligned(mem_addr_ip[1:0]);
  assign w_done      = (r_state == ST_WAIT) && data_rvalid_i;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] r_cnt;

  // Completion on the final counted cycle takes priority over the abort.
  assign w_timeout = (r_state != ST_IDLE) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) && !w_done;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_start) begin
      r_cnt <= '0;
    end else if (r_state != ST_IDLE) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    data_req_op = 1'b0;
    lsu_busy_op = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        data_req_op = 1'b1;
        lsu_busy_op = 1'b1;
        if (data_gnt_i) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        lsu_busy_op = 1'b1;
        if (data_rvalid_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (w_timeout) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // Bus fields are captured once at accept and held, so they stay stable through any gnt delay.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_we    <= 1'b0;
      r_be    <= 4'h0;
      r_addr  <= '0;
      r_wdata <= 32'h0;
    end else if (w_start) begin
      r_we    <= (lsu_operator_ip == LSU_SW);
      r_be    <= LSU_BE_WORD;
      r_addr  <= mem_addr_ip;
      r_wdata <= mem_wdata_ip;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ldata      <= 32'h0;
      r_load_vld   <= 1'b0;
      r_misaligned <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_load_vld   <= w_done && !r_we;
      r_misaligned <= w_misalign;
      r_timeout    <= w_timeout;
      if (w_done && !r_we) begin
        r_ldata <= data_rdata_i;
      end
    end
  end

  assign data_we_op        = r_we;
  assign data_be_op        = r_be;
  assign data_addr_op      = r_addr;
  assign data_wdata_op     = r_wdata;
  assign load_mem_data_op  = r_ldata;
  assign load_valid_op     = r_load_vld;
  assign misaligned_err_op = r_misaligned;
  assign timeout_err_op    = r_timeout;

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Transaction-level bench: each op is expanded into its expected per-cycle bus/stall/pulse timeline.
module tb_lsu_mem_sequencer;
  import lsu_mem_sequencer_pkg::*;

  localparam int AW = 32;
  localparam int TO = 8;
`ifdef LSU_TIMEOUT_EN
  localparam int MAXD = 2;
`else
  localparam int MAXD = 6;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          lsu_en_ip, alu_valid_ip, data_gnt_i, data_rvalid_i;
  logic [1:0]    lsu_operator_ip;
  logic [AW-1:0] mem_addr_ip;
  logic [31:0]   mem_wdata_ip, data_rdata_i;
  logic          data_req_op, data_we_op, lsu_busy_op;
  logic [3:0]    data_be_op;
  logic [AW-1:0] data_addr_op;
  logic [31:0]   data_wdata_op, load_mem_data_op;
  logic          load_valid_op, misaligned_err_op, timeout_err_op;

  always #5 clock = ~clock;

  lsu_mem_sequencer #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset),
    .lsu_en_ip(lsu_en_ip), .lsu_operator_ip(lsu_operator_ip), .alu_valid_ip(alu_valid_ip),
    .mem_addr_ip(mem_addr_ip), .mem_wdata_ip(mem_wdata_ip),
    .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
    .data_req_op(data_req_op), .data_we_op(data_we_op), .data_be_op(data_be_op),
    .data_addr_op(data_addr_op), .data_wdata_op(data_wdata_op), .lsu_busy_op(lsu_busy_op),
    .load_mem_data_op(load_mem_data_op), .load_valid_op(load_valid_op),
    .misaligned_err_op(misaligned_err_op), .timeout_err_op(timeout_err_op)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Expected values for the current cycle, plus pulses scheduled for the next one.
  bit          chk_on = 1'b0;
  logic        e_req = 0, e_busy = 0, e_lv = 0, e_mis = 0, e_to = 0, e_we = 0;
  logic [31:0] e_addr = 0, e_wdata = 0, e_ldata = 0;
  logic        p_lv = 0, p_mis = 0, p_to = 0;
  logic [31:0] p_ld = 0;

  int req_cnt = 0, lv_cnt = 0;
  int lv_seen = -1, mis_seen = -1, to_seen = -1;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (chk_on) begin
      chk1("busy", lsu_busy_op, e_busy);
      chk1("req", data_req_op, e_req);
      chk1("load_valid", load_valid_op, e_lv);
      chk1("misaligned", misaligned_err_op, e_mis);
      chk1("timeout", timeout_err_op, e_to);
      chk32("load_data", load_mem_data_op, e_ldata);
      if (e_req) begin
        chk32("addr", data_addr_op, e_addr);
        chk1("we", data_we_op, e_we);
        chk32("be", 32'(data_be_op), 32'h0000_000F);
        chk32("wdata", data_wdata_op, e_wdata);
      end
      if (data_req_op) req_cnt++;
      if (load_valid_op) begin lv_cnt++; lv_seen = cyc; end
      if (misaligned_err_op) mis_seen = cyc;
      if (timeout_err_op) to_seen = cyc;
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
    e_lv = p_lv; e_mis = p_mis; e_to = p_to;
    if (p_lv) e_ldata = p_ld;
    p_lv = 0; p_mis = 0; p_to = 0;
  endtask

  task automatic set_idle_inputs();
    lsu_en_ip       = 1'($urandom_range(0, 1));
    alu_valid_ip    = lsu_en_ip ? 1'b0 : 1'($urandom_range(0, 1));
    lsu_operator_ip = 2'($urandom_range(0, 3));
    mem_addr_ip     = $urandom;
    mem_wdata_ip    = $urandom;
    data_gnt_i      = 1'b0;
    data_rvalid_i   = 1'b0;
    data_rdata_i    = $urandom;
  endtask

  // Upstream garbage while busy: the sequencer must ignore all of it.
  task automatic busy_junk();
    lsu_en_ip       = 1'($urandom_range(0, 1));
    alu_valid_ip    = 1'($urandom_range(0, 1));
    lsu_operator_ip = 2'($urandom_range(0, 3));
    mem_addr_ip     = $urandom;
    mem_wdata_ip    = $urandom;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      e_busy = 0; e_req = 0;
      set_idle_inputs();
    end
  endtask

  // Called in an IDLE cycle; returns positioned at the first IDLE cycle after the op.
  task automatic do_txn(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input int g, input int r, input bit coin, input logic [31:0] rd,
                        output int acc);
    e_busy = 0; e_req = 0;
    lsu_en_ip = 1; alu_valid_ip = 1; lsu_operator_ip = op;
    mem_addr_ip = addr; mem_wdata_ip = wd;
    data_gnt_i = 0; data_rvalid_i = 0;
    acc = cyc;
    if (op != LSU_LW && op != LSU_SW) begin
      idle_cycles(1);
      return;
    end
    if (addr[1:0] != 2'b00) begin
      p_mis = 1;
      idle_cycles(1);
      return;
    end
    e_addr = addr; e_we = (op == LSU_SW); e_wdata = wd;
    for (int i = 0; i <= g; i++) begin
      next_cycle();
      e_busy = 1; e_req = 1;
      busy_junk();
      data_gnt_i    = (i == g);
      data_rvalid_i = (i == g && coin) ? 1'b1 : 1'($urandom_range(0, 1));
      data_rdata_i  = $urandom;
    end
    for (int i = 0; i <= r; i++) begin
      next_cycle();
      e_busy = 1; e_req = 0;
      busy_junk();
      data_gnt_i    = 0;
      data_rvalid_i = (i == r);
      data_rdata_i  = (i == r) ? rd : $urandom;
    end
    if (op == LSU_LW) begin
      p_lv = 1; p_ld = rd;
    end
    idle_cycles(1);
  endtask

  task automatic reset_in_wait();
    e_busy = 0; e_req = 0;
    lsu_en_ip = 1; alu_valid_ip = 1; lsu_operator_ip = LSU_LW;
    mem_addr_ip = 32'h0000_0400; mem_wdata_ip = 0;
    e_addr = 32'h0000_0400; e_we = 0; e_wdata = 0;
    next_cycle();
    e_busy = 1; e_req = 1; busy_junk(); data_gnt_i = 1; data_rvalid_i = 0;
    next_cycle();
    e_busy = 1; e_req = 0; busy_junk(); data_gnt_i = 0; data_rvalid_i = 0;
    #1 reset = 0;
    #1;
    chk1("rst_req_now", data_req_op, 1'b0);
    chk1("rst_busy_now", lsu_busy_op, 1'b0);
    chk32("rst_ldata_now", load_mem_data_op, 32'h0);
    e_busy = 0; e_ldata = 0;
    next_cycle();
    reset = 1;
    e_busy = 0; e_req = 0;
    set_idle_inputs();
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic timeout_seq(output int acc);
    e_busy = 0; e_req = 0;
    lsu_en_ip = 1; alu_valid_ip = 1; lsu_operator_ip = LSU_LW;
    mem_addr_ip = 32'h0000_0300; mem_wdata_ip = 32'h5555_AAAA;
    e_addr = 32'h0000_0300; e_we = 0; e_wdata = 32'h5555_AAAA;
    acc = cyc;
    for (int i = 0; i < TO; i++) begin
      next_cycle();
      e_busy = 1; e_req = 1;
      busy_junk(); data_gnt_i = 0; data_rvalid_i = 0;
    end
    p_to = 1;
    next_cycle();
    e_busy = 0; e_req = 0;
    set_idle_inputs();
    data_rvalid_i = 1; data_rdata_i = 32'h0BAD_0BAD;
    idle_cycles(1);
  endtask
`endif

  initial begin
    int acc, base_req, base_lv, g, r, sel;
    logic [1:0]  op;
    logic [31:0] a;
    set_idle_inputs();
    #2;
    chk1("reset_busy", lsu_busy_op, 1'b0);
    chk1("reset_req", data_req_op, 1'b0);
    chk1("reset_we", data_we_op, 1'b0);
    chk32("reset_be", 32'(data_be_op), 32'h0);
    chk32("reset_addr", data_addr_op, 32'h0);
    chk32("reset_wdata", data_wdata_op, 32'h0);
    chk32("reset_ldata", load_mem_data_op, 32'h0);
    chk1("reset_lv", load_valid_op, 1'b0);
    chk1("reset_mis", misaligned_err_op, 1'b0);
    chk1("reset_to", timeout_err_op, 1'b0);
    @(posedge clock);
    #1 reset = 1;
    chk_on = 1;
    idle_cycles(2);

    do_txn(LSU_LW, 32'h0000_0100, 32'h0, 0, 0, 0, 32'hDEAD_BEEF, acc);
    idle_cycles(1);
    chk32("lw_latency", 32'(lv_seen - acc), 32'd3);
    chk32("lw_data", load_mem_data_op, 32'hDEAD_BEEF);

    base_req = req_cnt; base_lv = lv_cnt;
    do_txn(LSU_SW, 32'h0000_0204, 32'h1234_5678, 3, 1, 0, 32'hFFFF_FFFF, acc);
    idle_cycles(1);
    chk32("sw_req_cycles", 32'(req_cnt - base_req), 32'd4);
    chk32("sw_no_load_valid", 32'(lv_cnt - base_lv), 32'd0);
    chk32("sw_addr_held", data_addr_op, 32'h0000_0204);
    chk32("sw_wdata_held", data_wdata_op, 32'h1234_5678);
    chk32("sw_ldata_kept", load_mem_data_op, 32'hDEAD_BEEF);

    base_req = req_cnt;
    do_txn(LSU_LW, 32'h0000_0102, 32'h0, 0, 0, 0, 32'h0, acc);
    idle_cycles(1);
    chk32("misaligned_latency", 32'(mis_seen - acc), 32'd1);
    chk32("misaligned_no_req", 32'(req_cnt - base_req), 32'd0);

    reset_in_wait();
    do_txn(LSU_LW, 32'h0000_0100, 32'h0, 0, 0, 0, 32'hCAFE_F00D, acc);
    idle_cycles(1);
    chk32("after_reset_lw_data", load_mem_data_op, 32'hCAFE_F00D);

    do_txn(LSU_LW, 32'h0000_0010, 32'h0, 1, 2, 1, 32'h0A0B_0C0D, acc);
    idle_cycles(1);
    chk32("coincident_latency", 32'(lv_seen - acc), 32'd6);

`ifdef LSU_TIMEOUT_EN
    timeout_seq(acc);
    idle_cycles(1);
    chk32("timeout_latency", 32'(to_seen - acc), 32'(TO + 1));
    chk32("timeout_ldata_kept", load_mem_data_op, 32'h0A0B_0C0D);
`else
    do_txn(LSU_LW, 32'h0000_0020, 32'h0, 20, 0, 0, 32'h7777_1111, acc);
    idle_cycles(1);
    chk32("no_timeout_latency", 32'(lv_seen - acc), 32'd23);
`endif

    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 19);
      if (sel < 9)        op = LSU_LW;
      else if (sel < 18)  op = LSU_SW;
      else if (sel == 18) op = LSU_NONE;
      else                op = 2'b11;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      g = $urandom_range(0, MAXD);
      r = $urandom_range(0, MAXD);
      do_txn(op, a, $urandom, g, r, 1'($urandom_range(0, 1)), $urandom, acc);
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
    end
    idle_cycles(2);
    chk_on = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
